// File: rtl/timer_counter_if.sv
// rtl/timer_counter_if.sv - CPU-side register bus between the address bridge and a timer_counter instance.
interface timer_counter_if;
    logic [31:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    modport master (
        output Addr,
        output WE,
        output Din,
        input  Dout,
        input  IRQ
    );

    modport slave (
        input  Addr,
        input  WE,
        input  Din,
        output Dout,
        output IRQ
    );
endinterface

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - Memory-mapped programmable down-counter timer (CTRL / PRESET / COUNT) with IRQ.
module timer_counter #(
    parameter int CTRL_BITS = 4
) (
    input  logic            clk,
    input  logic            reset,
    timer_counter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_CTRL   = 2'd0;
    localparam logic [1:0] SEL_PRESET = 2'd1;
    localparam logic [1:0] SEL_COUNT  = 2'd2;

    state_t                 state;
    logic [CTRL_BITS-1:0]   ctrl;
    logic [31:0]            preset;
    logic [31:0]            count;
    logic                   irq_flag;

    logic                   enable;
    logic [1:0]             mode;
    logic                   irq_mask;
    logic [1:0]             sel;
    logic                   addr_unused;

    assign enable      = ctrl[0];
    assign mode        = ctrl[2:1];
    assign irq_mask    = ctrl[3];
    assign sel         = bus.Addr[3:2];
    assign addr_unused = ^{bus.Addr[31:4], bus.Addr[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ctrl     <= '0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state    <= LOAD;
                        irq_flag <= 1'b0;
                    end
                end
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        // Reaching 1 (or a zero preset) expires; COUNT saturates at 0.
                        count    <= '0;
                        irq_flag <= 1'b1;
                        state    <= INT;
                    end
                end
                INT: begin
                    if (mode == 2'b00) begin
                        ctrl[0] <= 1'b0;
                    end else begin
                        irq_flag <= 1'b0;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Placed after the FSM so a same-edge CPU write to CTRL overrides the Enable clear.
            if (bus.WE) begin
                case (sel)
                    SEL_CTRL:   ctrl   <= bus.Din[CTRL_BITS-1:0];
                    SEL_PRESET: preset <= bus.Din;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        bus.Dout = '0;
        case (sel)
            SEL_CTRL:   bus.Dout = {{(32-CTRL_BITS){1'b0}}, ctrl};
            SEL_PRESET: bus.Dout = preset;
            SEL_COUNT:  bus.Dout = count;
            default:    bus.Dout = '0;
        endcase
    end

    assign bus.IRQ = irq_flag & irq_mask;

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - Directed and randomized checks of timer_counter against a behavioural model.
module tb_timer_counter;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    timer_counter_if bus ();

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: phase 0 waiting, 1 about to load, 2 counting down, 3 just expired.
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_flag;
    int          m_phase;

    logic [31:0] obs [4];
    logic        obs_irq;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic void model_edge(input bit we, input logic [31:0] a, input logic [31:0] d, input bit rst);
        logic [3:0]  n_ctrl;
        logic [31:0] n_count;
        logic        n_flag;
        int          n_phase;
        if (rst) begin
            m_ctrl = '0; m_preset = '0; m_count = '0; m_flag = 1'b0; m_phase = 0;
            return;
        end
        n_ctrl = m_ctrl; n_count = m_count; n_flag = m_flag; n_phase = m_phase;
        if (m_phase == 0 && m_ctrl[0]) begin
            n_phase = 1; n_flag = 1'b0;
        end else if (m_phase == 1) begin
            n_count = m_preset; n_phase = 2;
        end else if (m_phase == 2) begin
            if (!m_ctrl[0]) n_phase = 0;
            else if (m_count >= 2) n_count = m_count - 1;
            else begin n_count = 0; n_flag = 1'b1; n_phase = 3; end
        end else if (m_phase == 3) begin
            if (m_ctrl[2:1] == 2'b00) n_ctrl[0] = 1'b0;
            else n_flag = 1'b0;
            n_phase = 0;
        end
        if (we && a[3:2] == 2'd0) n_ctrl = d[3:0];
        if (we && a[3:2] == 2'd1) m_preset = d;
        m_ctrl = n_ctrl; m_count = n_count; m_flag = n_flag; m_phase = n_phase;
    endfunction

    function automatic logic [31:0] exp_dout(input int i);
        case (i)
            0:       return {28'b0, m_ctrl};
            1:       return m_preset;
            2:       return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_all();
        bus.WE = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.Addr = 32'(i * 4);
            #1;
            obs[i] = bus.Dout;
            check($sformatf("dout_a%0d", i * 4), bus.Dout, exp_dout(i));
        end
        obs_irq = bus.IRQ;
        check("irq", {31'b0, bus.IRQ}, {31'b0, m_ctrl[3] & m_flag});
    endtask

    task automatic step(input bit we, input logic [31:0] a, input logic [31:0] d, input bit rst);
        bus.Addr = a; bus.WE = we; bus.Din = d; reset = rst;
        @(posedge clk);
        model_edge(we, a, d, rst);
        #1;
        reset = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic settle();
        step(1'b1, 32'h0, 32'h0, 1'b0);
        idle(3);
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; bus.Addr = '0; bus.WE = 1'b0; bus.Din = '0;
        m_ctrl = '0; m_preset = '0; m_count = '0; m_flag = 1'b0; m_phase = 0;

        // Reset state
        step(1'b0, 32'd0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 32'd0, 1'b1);
        check("rst_ctrl", obs[0], 32'd0);
        check("rst_preset", obs[1], 32'd0);
        check("rst_count", obs[2], 32'd0);
        check("rst_irq", {31'b0, obs_irq}, 32'd0);

        // One-shot, PRESET=3
        step(1'b1, 32'h7F04, 32'd3, 1'b0);
        step(1'b1, 32'h7F00, 32'h9, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            idle(1);
            if (k >= 2) check("t2_count", obs[2], 32'(5 - k));
            check("t2_irq", {31'b0, obs_irq}, {31'b0, k == 5});
        end
        idle(1);
        check("t2_ctrl", obs[0], 32'h8);
        idle(2);
        check("t2_irq_held", {31'b0, obs_irq}, 32'd1);

        // Auto-reload, PRESET=2: pulse every 5 cycles
        step(1'b1, 32'h7F04, 32'd2, 1'b0);
        step(1'b1, 32'h7F00, 32'hB, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            idle(1);
            check("t3_irq", {31'b0, obs_irq}, {31'b0, (k >= 4) && ((k - 4) % 5 == 0)});
        end
        check("t3_ctrl", obs[0], 32'hB);

        // Enable cleared mid-count freezes COUNT, re-enable reloads
        settle();
        step(1'b1, 32'h7F04, 32'd8, 1'b0);
        step(1'b1, 32'h7F00, 32'h9, 1'b0);
        idle(4);
        check("t4_count6", obs[2], 32'd6);
        step(1'b1, 32'h7F00, 32'h8, 1'b0);
        for (int k = 0; k < 3; k++) begin
            idle(1);
            check("t4_hold", obs[2], 32'd5);
            check("t4_noirq", {31'b0, obs_irq}, 32'd0);
        end
        step(1'b1, 32'h7F00, 32'h9, 1'b0);
        idle(2);
        check("t4_reload", obs[2], 32'd8);

        // COUNT is read-only; PRESET change waits for the next load
        step(1'b1, 32'h7F08, 32'hFFFF, 1'b0);
        check("t5_ro", obs[2], 32'd7);
        step(1'b1, 32'h7F04, 32'd20, 1'b0);
        check("t5_no_early", obs[2], 32'd6);
        idle(7);
        step(1'b1, 32'h7F00, 32'h9, 1'b0);
        idle(2);
        check("t5_new_preset", obs[2], 32'd20);

        // IM=0 masks IRQ; setting IM exposes the held flag; reset mid-count
        settle();
        step(1'b1, 32'h7F04, 32'd1, 1'b0);
        step(1'b1, 32'h7F00, 32'h1, 1'b0);
        idle(4);
        check("t6_masked", {31'b0, obs_irq}, 32'd0);
        step(1'b1, 32'h7F00, 32'h8, 1'b0);
        check("t6_unmask", {31'b0, obs_irq}, 32'd1);
        step(1'b1, 32'h7F04, 32'd10, 1'b0);
        step(1'b1, 32'h7F00, 32'h9, 1'b0);
        idle(4);
        step(1'b0, 32'd0, 32'd0, 1'b1);
        check("t6_rst_ctrl", obs[0], 32'd0);
        check("t6_rst_preset", obs[1], 32'd0);
        check("t6_rst_count", obs[2], 32'd0);
        check("t6_rst_irq", {31'b0, obs_irq}, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            bit          we;
            bit          rst;
            logic [31:0] a;
            logic [31:0] d;
            we  = ($urandom_range(0, 9) < 2);
            rst = ($urandom_range(0, 199) == 0);
            a   = {$urandom} & 32'hFFFF_FFF3;
            a[3:2] = 2'($urandom_range(0, 3));
            if (a[3:2] == 2'd1 && $urandom_range(0, 3) != 0) d = 32'($urandom_range(0, 6));
            else d = $urandom;
            step(we, a, d, rst);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
